// File: rtl/reg_map_pkg.sv
// Shared definitions for the register-map responder: address offsets, FSM states,
// register select codes and reset values.
package reg_map_pkg;

    localparam int unsigned ADDR_CTRL     = 32'h000;
    localparam int unsigned ADDR_STATUS   = 32'h004;
    localparam int unsigned ADDR_SCRATCH  = 32'h008;
    localparam int unsigned ADDR_IRQ_STAT = 32'h00C;
    localparam int unsigned ADDR_IRQ_EN   = 32'h010;
    localparam int unsigned ADDR_CYCLE    = 32'h014;

    localparam logic [31:0] CTRL_RST     = 32'h0000_0000;
    localparam logic [31:0] SCRATCH_RST  = 32'h0000_0000;
    localparam logic [31:0] STATUS_RST   = 32'h0000_0000;
    localparam logic [31:0] CYCLE_RST    = 32'h0000_0000;
    localparam logic [7:0]  IRQ_STAT_RST = 8'h00;
    localparam logic [7:0]  IRQ_EN_RST   = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_STATUS,
        SEL_SCRATCH,
        SEL_IRQ_STAT,
        SEL_IRQ_EN,
        SEL_CYCLE,
        SEL_NONE
    } reg_sel_e;

    function automatic logic [31:0] bitMerge(input logic [31:0] oldVal,
                                             input logic [31:0] wrVal,
                                             input logic [31:0] biten);
        return (oldVal & ~biten) | (wrVal & biten);
    endfunction

endpackage

// File: rtl/reg_map_irq_bank.sv
// Interrupt status (W1C, hardware set wins over clear) and enable registers,
// with a registered interrupt output.
module reg_map_irq_bank
    import reg_map_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stat_clr,
    input  logic       i_en_wr,
    input  logic [7:0] i_wr_data,
    input  logic [7:0] i_biten,
    input  logic [7:0] i_hw_set,
    output logic [7:0] o_stat,
    output logic [7:0] o_en,
    output logic       o_irq
);

    logic [7:0] r_stat;
    logic [7:0] r_en;
    logic       r_irq;
    logic [7:0] w_clrMask;

    assign w_clrMask = i_stat_clr ? (i_wr_data & i_biten) : 8'h00;

    // Set is OR-ed after the clear so a simultaneous hardware pulse survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= IRQ_STAT_RST;
            r_en   <= IRQ_EN_RST;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_clrMask) | i_hw_set;
            if (i_en_wr) begin
                r_en <= (r_en & ~i_biten) | (i_wr_data & i_biten);
            end
            r_irq <= |(r_stat & r_en);
        end
    end

    assign o_stat = r_stat;
    assign o_en   = r_en;
    assign o_irq  = r_irq;

endmodule

// File: rtl/reg_map_responder.sv
// Bus register-map responder: accepts one request in IDLE, optionally waits,
// then returns a one-cycle response and commits writes as RESP ends.
module reg_map_responder
    import reg_map_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic [DATA_WIDTH-1:0] bus_wr_biten,
    output logic                  bus_ready,
    output logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  bus_err,
    input  logic [31:0]           hw_status,
    input  logic [7:0]            hw_irq_set,
    output logic [31:0]           ctrl_out,
    output logic                  irq
);

    localparam int WAIT_LAST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    state_e                r_state;
    state_e                w_next;
    logic [3:0]            r_waitCnt;
    reg_sel_e              r_sel;
    logic                  r_isWr;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic [DATA_WIDTH-1:0] r_biten;
    logic [31:0]           r_status;
    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_scratch;
    logic [31:0]           r_cycle;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_err;

    reg_sel_e              w_selIn;
    reg_sel_e              w_sel;
    logic                  w_isWr;
    logic [31:0]           w_status;
    logic [DATA_WIDTH-1:0] w_rdMux;
    logic                  w_errMux;
    logic                  w_accept;
    logic                  w_enterResp;
    logic                  w_commit;
    logic [7:0]            w_irqStat;
    logic [7:0]            w_irqEn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus_req) w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_waitCnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_ready   = (r_state == ST_RESP);
        bus_rd_data = bus_ready ? r_rdData : '0;
        bus_err     = bus_ready ? r_err : 1'b0;
    end

    always_comb begin
        w_selIn = SEL_NONE;
        if (bus_addr[1:0] == 2'b00) begin
            case (bus_addr)
                ADDR_WIDTH'(ADDR_CTRL):     w_selIn = SEL_CTRL;
                ADDR_WIDTH'(ADDR_STATUS):   w_selIn = SEL_STATUS;
                ADDR_WIDTH'(ADDR_SCRATCH):  w_selIn = SEL_SCRATCH;
                ADDR_WIDTH'(ADDR_IRQ_STAT): w_selIn = SEL_IRQ_STAT;
                ADDR_WIDTH'(ADDR_IRQ_EN):   w_selIn = SEL_IRQ_EN;
                ADDR_WIDTH'(ADDR_CYCLE):    w_selIn = SEL_CYCLE;
                default:                    w_selIn = SEL_NONE;
            endcase
        end
    end

    // With zero wait states RESP is entered on the accept edge, so use live inputs.
    assign w_accept    = (r_state == ST_IDLE) && bus_req;
    assign w_enterResp = (w_next == ST_RESP) && (r_state != ST_RESP);
    assign w_sel       = (r_state == ST_IDLE) ? w_selIn : r_sel;
    assign w_isWr      = (r_state == ST_IDLE) ? bus_req_is_wr : r_isWr;
    assign w_status    = (r_state == ST_IDLE) ? hw_status : r_status;
    assign w_commit    = (r_state == ST_RESP) && r_isWr;

    always_comb begin
        w_rdMux  = '0;
        w_errMux = 1'b0;
        case (w_sel)
            SEL_CTRL:     w_rdMux = r_ctrl;
            SEL_STATUS:   w_rdMux = DATA_WIDTH'(w_status);
            SEL_SCRATCH:  w_rdMux = r_scratch;
            SEL_IRQ_STAT: w_rdMux = DATA_WIDTH'(w_irqStat);
            SEL_IRQ_EN:   w_rdMux = DATA_WIDTH'(w_irqEn);
            SEL_CYCLE:    w_rdMux = DATA_WIDTH'(r_cycle);
            default:      w_errMux = 1'b1;
        endcase
        if (w_isWr) begin
            w_rdMux = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= 4'd0;
            r_sel     <= SEL_NONE;
            r_isWr    <= 1'b0;
            r_wrData  <= '0;
            r_biten   <= '0;
            r_status  <= STATUS_RST;
            r_ctrl    <= CTRL_RST;
            r_scratch <= SCRATCH_RST;
            r_cycle   <= CYCLE_RST;
            r_rdData  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_accept) begin
                r_sel     <= w_selIn;
                r_isWr    <= bus_req_is_wr;
                r_wrData  <= bus_wr_data;
                r_biten   <= bus_wr_biten;
                r_status  <= hw_status;
                r_waitCnt <= 4'(WAIT_LAST);
            end else if (r_state == ST_WAIT && r_waitCnt != 4'd0) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            if (w_enterResp) begin
                r_rdData <= w_rdMux;
                r_err    <= w_errMux;
            end
            if (w_commit && r_sel == SEL_CTRL) begin
                r_ctrl <= bitMerge(r_ctrl, r_wrData, r_biten);
            end
            if (w_commit && r_sel == SEL_SCRATCH) begin
                r_scratch <= bitMerge(r_scratch, r_wrData, r_biten);
            end
        end
    end

    reg_map_irq_bank u_irqBank (
        .clk        (clk),
        .rst        (rst),
        .i_stat_clr (w_commit && r_sel == SEL_IRQ_STAT),
        .i_en_wr    (w_commit && r_sel == SEL_IRQ_EN),
        .i_wr_data  (r_wrData[7:0]),
        .i_biten    (r_biten[7:0]),
        .i_hw_set   (hw_irq_set),
        .o_stat     (w_irqStat),
        .o_en       (w_irqEn),
        .o_irq      (irq)
    );

    assign ctrl_out = r_ctrl;

endmodule

// File: tb/tb_reg_map_responder.sv
// Directed bench for reg_map_responder: three instances (0, 3 and 5 wait states)
// share one bus; each scenario task checks the instance it targets.
module tb_reg_map_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_req_is_wr = 1'b0;
    logic [10:0] bus_addr = '0;
    logic [31:0] bus_wr_data = '0;
    logic [31:0] bus_wr_biten = '0;
    logic [31:0] hw_status = 32'hA5A5_0F0F;
    logic [7:0]  hw_irq_set = 8'h00;

    logic [2:0]  ready;
    logic [2:0]  errs;
    logic [2:0]  irqOut;
    logic [31:0] rdData [3];
    logic [31:0] ctrlOut [3];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reg_map_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_ready(ready[0]), .bus_rd_data(rdData[0]), .bus_err(errs[0]),
        .hw_status(hw_status), .hw_irq_set(hw_irq_set), .ctrl_out(ctrlOut[0]), .irq(irqOut[0]));

    reg_map_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_ready(ready[1]), .bus_rd_data(rdData[1]), .bus_err(errs[1]),
        .hw_status(hw_status), .hw_irq_set(hw_irq_set), .ctrl_out(ctrlOut[1]), .irq(irqOut[1]));

    reg_map_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .WAIT_STATES(5)) dut5 (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_ready(ready[2]), .bus_rd_data(rdData[2]), .bus_err(errs[2]),
        .hw_status(hw_status), .hw_irq_set(hw_irq_set), .ctrl_out(ctrlOut[2]), .irq(irqOut[2]));

    // Drives one request for a single cycle, then watches instance idx for its
    // response; latency counts falling edges after the drive edge, -1 if none.
    task automatic applyStimulus(input int idx, input logic isWr, input logic [10:0] addr,
                                 input logic [31:0] data, input logic [31:0] biten,
                                 output logic [31:0] rd, output logic err, output int lat);
        lat = -1;
        rd  = '0;
        err = 1'b0;
        @(negedge clk);
        bus_req       = 1'b1;
        bus_req_is_wr = isWr;
        bus_addr      = addr;
        bus_wr_data   = data;
        bus_wr_biten  = biten;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus_req = 1'b0;
            if (lat < 0 && ready[idx]) begin
                lat = k;
                rd  = rdData[idx];
                err = errs[idx];
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        err;
        int          lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (ready !== 3'b000) begin bad++; $display("[TB] FAIL rst_ready: got %b want 000", ready); end
        total++; if (rdData[0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_rd: got %h want 00000000", rdData[0]); end
        total++; if (errs !== 3'b000) begin bad++; $display("[TB] FAIL rst_err: got %b want 000", errs); end
        total++; if (ctrlOut[0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_ctrl: got %h want 00000000", ctrlOut[0]); end
        total++; if (irqOut !== 3'b000) begin bad++; $display("[TB] FAIL rst_irq: got %b want 000", irqOut); end
        rst = 1'b0;
        applyStimulus(0, 1'b0, 11'h014, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h1) begin bad++; $display("[TB] FAIL cycle_first: got %h want 00000001", rd); end
        applyStimulus(0, 1'b0, 11'h008, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_scratch: got %h want 00000000", rd); end
        applyStimulus(0, 1'b0, 11'h010, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL rst_irq_en: got %h want 00000000", rd); end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(0, 1'b1, 11'h000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, rd, err, lat);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL ctrl_lat: got %0d want 1", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL ctrl_err: got %b want 0", err); end
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL ctrl_wr_rd: got %h want 00000000", rd); end
        total++; if (ctrlOut[0] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL ctrl_out: got %h want deadbeef", ctrlOut[0]); end
        applyStimulus(0, 1'b1, 11'h000, 32'h0000_0000, 32'h0000_FF00, rd, err, lat);
        total++; if (ctrlOut[0] !== 32'hDEAD_00EF) begin bad++; $display("[TB] FAIL ctrl_biten: got %h want dead00ef", ctrlOut[0]); end
        applyStimulus(0, 1'b0, 11'h000, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'hDEAD_00EF) begin bad++; $display("[TB] FAIL ctrl_read: got %h want dead00ef", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(1, 1'b1, 11'h008, 32'h0, 32'hFFFF_FFFF, rd, err, lat);
        applyStimulus(1, 1'b1, 11'h008, 32'h1234_5678, 32'h0000_FFFF, rd, err, lat);
        total++; if (lat !== 4) begin bad++; $display("[TB] FAIL ws3_wr_lat: got %0d want 4", lat); end
        applyStimulus(1, 1'b0, 11'h008, 32'h0, 32'h0, rd, err, lat);
        total++; if (lat !== 4) begin bad++; $display("[TB] FAIL ws3_rd_lat: got %0d want 4", lat); end
        total++; if (rd !== 32'h0000_5678) begin bad++; $display("[TB] FAIL ws3_rd_data: got %h want 00005678", rd); end
        applyStimulus(2, 1'b0, 11'h008, 32'h0, 32'h0, rd, err, lat);
        total++; if (lat !== 6) begin bad++; $display("[TB] FAIL ws5_rd_lat: got %0d want 6", lat); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(0, 1'b0, 11'h7FC, 32'h0, 32'h0, rd, err, lat);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_7fc: got %b want 1", err); end
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_7fc_rd: got %h want 00000000", rd); end
        applyStimulus(0, 1'b0, 11'h002, 32'h0, 32'h0, rd, err, lat);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_002: got %b want 1", err); end
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_002_rd: got %h want 00000000", rd); end
        applyStimulus(0, 1'b1, 11'h002, 32'h0, 32'hFFFF_FFFF, rd, err, lat);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_wr_002: got %b want 1", err); end
        total++; if (ctrlOut[0] !== 32'hDEAD_00EF) begin bad++; $display("[TB] FAIL err_ctrl_kept: got %h want dead00ef", ctrlOut[0]); end
        applyStimulus(0, 1'b1, 11'h00A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rd, err, lat);
        applyStimulus(0, 1'b0, 11'h008, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0000_5678) begin bad++; $display("[TB] FAIL err_scratch_kept: got %h want 00005678", rd); end
        applyStimulus(0, 1'b1, 11'h004, 32'h1111_1111, 32'hFFFF_FFFF, rd, err, lat);
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL ro_wr_err: got %b want 0", err); end
        applyStimulus(0, 1'b0, 11'h004, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'hA5A5_0F0F) begin bad++; $display("[TB] FAIL status_read: got %h want a5a50f0f", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        err;
        int          lat;
        applyStimulus(0, 1'b1, 11'h010, 32'hFFFF_FF01, 32'hFFFF_FFFF, rd, err, lat);
        applyStimulus(0, 1'b0, 11'h010, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("[TB] FAIL irq_en_read: got %h want 00000001", rd); end
        @(negedge clk);
        hw_irq_set = 8'h01;
        @(negedge clk);
        hw_irq_set = 8'h00;
        total++; if (irqOut[0] !== 1'b0) begin bad++; $display("[TB] FAIL irq_early: got %b want 0", irqOut[0]); end
        @(negedge clk);
        total++; if (irqOut[0] !== 1'b1) begin bad++; $display("[TB] FAIL irq_set: got %b want 1", irqOut[0]); end
        // Clear write whose commit edge coincides with a fresh set pulse.
        @(negedge clk);
        bus_req = 1'b1; bus_req_is_wr = 1'b1; bus_addr = 11'h00C;
        bus_wr_data = 32'h0000_0001; bus_wr_biten = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_req = 1'b0;
        total++; if (ready[0] !== 1'b1) begin bad++; $display("[TB] FAIL w1c_ready: got %b want 1", ready[0]); end
        hw_irq_set = 8'h01;
        @(negedge clk);
        hw_irq_set = 8'h00;
        repeat (20) @(negedge clk);
        applyStimulus(0, 1'b0, 11'h00C, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0000_0001) begin bad++; $display("[TB] FAIL set_wins: got %h want 00000001", rd); end
        total++; if (irqOut[0] !== 1'b1) begin bad++; $display("[TB] FAIL irq_held: got %b want 1", irqOut[0]); end
        applyStimulus(0, 1'b1, 11'h00C, 32'h0000_0001, 32'hFFFF_FFFF, rd, err, lat);
        applyStimulus(0, 1'b0, 11'h00C, 32'h0, 32'h0, rd, err, lat);
        total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL w1c_clear: got %h want 00000000", rd); end
        total++; if (irqOut[0] !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared: got %b want 0", irqOut[0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          seen;
        seen = 0;
        @(negedge clk);
        bus_req = 1'b1; bus_req_is_wr = 1'b1; bus_addr = 11'h000;
        bus_wr_data = 32'h1111_2222; bus_wr_biten = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_req = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready[2] !== 1'b0) begin bad++; $display("[TB] FAIL mid_in_wait: got %b want 0", ready[2]); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready[2]) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL mid_no_ready: got %0d pulses want 0", seen); end
        total++; if (ctrlOut[2] !== 32'h0) begin bad++; $display("[TB] FAIL mid_no_commit: got %h want 00000000", ctrlOut[2]); end
        applyStimulus(2, 1'b1, 11'h000, 32'h0000_ABCD, 32'hFFFF_FFFF, rd, err, lat);
        total++; if (lat !== 6) begin bad++; $display("[TB] FAIL mid_next_lat: got %0d want 6", lat); end
        total++; if (ctrlOut[2] !== 32'h0000_ABCD) begin bad++; $display("[TB] FAIL mid_next_ctrl: got %h want 0000abcd", ctrlOut[2]); end
    endtask

    task automatic test_back_to_back();
        int ws [3] = '{0, 3, 5};
        int prev [3] = '{-1, -1, -1};
        int cnt [3] = '{0, 0, 0};
        @(negedge clk);
        bus_req = 1'b1; bus_req_is_wr = 1'b0; bus_addr = 11'h008;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (ready[i]) begin
                    if (prev[i] >= 0) begin
                        total++;
                        if (n - prev[i] !== 2 + ws[i]) begin
                            bad++;
                            $display("[TB] FAIL b2b_gap%0d: got %0d want %0d", i, n - prev[i], 2 + ws[i]);
                        end
                    end
                    prev[i] = n;
                    cnt[i]++;
                end else begin
                    total++;
                    if (rdData[i] !== 32'h0) begin
                        bad++;
                        $display("[TB] FAIL idle_rd%0d: got %h want 00000000", i, rdData[i]);
                    end
                end
            end
        end
        bus_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cnt[i] < 60 / (2 + ws[i]) - 1) begin
                bad++;
                $display("[TB] FAIL b2b_count%0d: got %0d want at least %0d", i, cnt[i], 60 / (2 + ws[i]) - 1);
            end
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting");
        test_reset();
        test_ctrl_write();
        test_wait_states();
        test_errors();
        test_irq();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
